// File: rtl/data_memory_pkg.sv
// Shared datapath widths and constants for the microRISC core (ALU, register file,
// instruction memory and data memory all size themselves from here).
package data_memory_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int DMEM_DEPTH = 256;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-organised data RAM for the MEM stage: synchronous write, combinational read.
// Optional macro DMEM_WRITE_FWD_EN forwards write_data onto read_data during a same-cycle read/write.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = data_memory_pkg::ADDR_W,
    parameter int DATA_W = data_memory_pkg::DATA_W,
    parameter int DEPTH  = data_memory_pkg::DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-2:0] w_word_idx;
    logic              w_unused_lsb;

    // Byte address to word index; the LSB is dropped so odd addresses alias downward.
    assign w_word_idx   = addr[ADDR_W-1:1];
    assign w_unused_lsb = addr[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ZERO;
            end
        end else if (mem_write) begin
            r_mem[w_word_idx] <= write_data;
        end
    end

    always_comb begin
        read_data = ZERO;
        if (rst_n && mem_read) begin
`ifdef DMEM_WRITE_FWD_EN
            if (mem_write) begin
                read_data = write_data;
            end else begin
                read_data = r_mem[w_word_idx];
            end
`else
            read_data = r_mem[w_word_idx];
`endif
        end
    end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected read words are queued when a read is
// presented and popped when read_data is sampled 1 ns later.
module tb_data_memory;
    import data_memory_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    logic [DATA_W-1:0] ref_mem [DMEM_DEPTH];
    logic [DATA_W-1:0] sb_q [$];
    int                n_vec;
    int                n_err;

    data_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, obs=running req=finished");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: read_data=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic sample(input string tag);
        logic [DATA_W-1:0] exp;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, read_data=0x%04h", tag, read_data);
        end else begin
            exp = sb_q.pop_front();
            check_vec(tag, read_data, exp);
        end
    endtask

    // Present a read (no write) and compare 1 ns later against the model.
    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic rd);
        mem_write = 1'b0;
        mem_read  = rd;
        addr      = a;
        sb_q.push_back((rd && rst_n) ? ref_mem[a[ADDR_W-1:1]] : ZERO_WORD);
        #1;
        sample(tag);
    endtask

    // Drive a write from the falling edge, take one rising edge, update the model.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        addr       = a;
        write_data = d;
        @(posedge clk);
        if (rst_n) ref_mem[a[ADDR_W-1:1]] = d;
        #1;
        mem_write = 1'b0;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DMEM_DEPTH; i++) ref_mem[i] = ZERO_WORD;
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        write_data = '0;
        clear_ref();

        // Reset pulse; read_data must be forced low even with mem_read high.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 9'h002;
        sb_q.push_back(ZERO_WORD);
        #1;
        sample("reset_forced_zero");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_chk("reset_0x002", 9'h002, 1'b1);
        rd_chk("reset_0x1FE", 9'h1FE, 1'b1);

        wr(9'h002, 16'hABCD);
        rd_chk("wr_rd_0x002", 9'h002, 1'b1);

        wr(9'h004, 16'h1234);
        wr(9'h006, 16'h5678);
        rd_chk("rd_0x004", 9'h004, 1'b1);
        rd_chk("rd_0x006", 9'h006, 1'b1);
        rd_chk("rd_disabled", 9'h004, 1'b0);
        rd_chk("alias_0x005", 9'h005, 1'b1);
        rd_chk("alias_0x003", 9'h003, 1'b1);

        // Same-cycle read and write to one word.
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        addr       = 9'h008;
        write_data = 16'h9999;
`ifdef DMEM_WRITE_FWD_EN
        sb_q.push_back(16'h9999);
`else
        sb_q.push_back(16'h0000);
`endif
        #1;
        sample("rw_before_edge");
        @(posedge clk);
        ref_mem[9'h008 >> 1] = 16'h9999;
        sb_q.push_back(16'h9999);
        #1;
        sample("rw_after_edge");
        mem_write = 1'b0;
        rd_chk("rw_readback", 9'h008, 1'b1);

        // Reset with a pending write: the write is lost and the array cleared.
        @(negedge clk);
        rst_n      = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        addr       = 9'h00A;
        write_data = 16'h5555;
        sb_q.push_back(ZERO_WORD);
        #1;
        sample("rst_midwrite_forced");
        @(posedge clk);
        clear_ref();
        #1;
        mem_write = 1'b0;
        rst_n     = 1'b1;
        rd_chk("rst_lost_0x00A", 9'h00A, 1'b1);
        rd_chk("rst_cleared_0x004", 9'h004, 1'b1);
        rd_chk("rst_cleared_0x008", 9'h008, 1'b1);

        // Random writes with read-back of random addresses, model-tracked.
        for (int i = 0; i < 60; i++) begin
            ra     = ADDR_W'($urandom_range(0, 511));
            rd_val = DATA_W'($urandom);
            wr(ra, rd_val);
            rd_chk("rand_wr_rd", ra ^ 9'h001, 1'b1);
            rd_chk("rand_rd", ADDR_W'($urandom_range(0, 511)), 1'b1);
        end
        wr(9'h1FE, 16'hFFFF);
        rd_chk("top_word_0x1FF", 9'h1FF, 1'b1);
        rd_chk("bottom_word_0x000", 9'h000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_memory
